// File: rtl/vegeta_weight_loader.sv
// Transmit end of the VEGETA PE weight-transfer interface: streams NUM_ROWS compressed
// weight rows into a PE column chain and flips the double-buffer select after each full load.
module vegeta_weight_loader #(
  parameter int ALPHA          = 4,
  parameter int BETA           = 4,
  parameter int MUL_DATAWIDTH  = 8,
  parameter int META_DATA_SIZE = 2,
  parameter int NUM_ROWS       = 4,
  parameter int W              = ALPHA * BETA * (MUL_DATAWIDTH + META_DATA_SIZE),
  parameter int CW             = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    buf_free,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic [W-1:0]  weight_out,
  output logic          weight_transferring_out,
  output logic          wb_sel,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] row_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BUF = 2'd1,
    STREAM   = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST_ROW = CW'(NUM_ROWS - 1);

  state_t state_r;

  // Handshake and status derived directly from the state register.
  assign in_ready = (state_r == STREAM);
  assign busy     = (state_r != IDLE);

  // Load sequencer; the final beat stays on weight_out during the one-cycle DONE state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r                 <= IDLE;
      weight_out              <= {W{1'b0}};
      weight_transferring_out <= 1'b0;
      wb_sel                  <= 1'b0;
      row_cnt                 <= {CW{1'b0}};
      done                    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          weight_transferring_out <= 1'b0;
          done                    <= 1'b0;
          if (start) begin
            state_r <= WAIT_BUF;
            row_cnt <= {CW{1'b0}};
          end
        end
        WAIT_BUF: begin
          weight_transferring_out <= 1'b0;
          done                    <= 1'b0;
          if (abort) begin
            state_r <= IDLE;
          end else if (buf_free[wb_sel]) begin
            state_r <= STREAM;
          end
        end
        STREAM: begin
          if (abort) begin
            state_r                 <= IDLE;
            weight_transferring_out <= 1'b0;
          end else if (in_valid) begin
            weight_out              <= in_data;
            weight_transferring_out <= 1'b1;
            if (row_cnt == LAST_ROW) begin
              row_cnt <= {CW{1'b0}};
              state_r <= DONE;
              done    <= 1'b1;
            end else begin
              row_cnt <= row_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
          end else begin
            // Bubble: the chain only shifts while transferring is high, so data may hold.
            weight_transferring_out <= 1'b0;
          end
        end
        DONE: begin
          weight_transferring_out <= 1'b0;
          done                    <= 1'b0;
          wb_sel                  <= ~wb_sel;
          state_r                 <= IDLE;
        end
        default: begin
          state_r                 <= IDLE;
          weight_transferring_out <= 1'b0;
          done                    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vegeta_weight_loader.sv
// Scoreboard bench for vegeta_weight_loader: a load-level model predicts accepted rows,
// and a negedge monitor checks every transferring beat against the predicted queue.
module tb_vegeta_weight_loader;

  localparam int ALPHA = 4;
  localparam int BETA  = 4;
  localparam int MUL   = 8;
  localparam int META  = 2;
  localparam int NR    = 4;
  localparam int W     = ALPHA * BETA * (MUL + META);
  localparam int CW    = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [1:0]    buf_free;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [W-1:0]  weight_out;
  logic          weight_transferring_out;
  logic          wb_sel;
  logic          busy;
  logic          done;
  logic [CW-1:0] row_cnt;

  vegeta_weight_loader #(
    .ALPHA(ALPHA), .BETA(BETA), .MUL_DATAWIDTH(MUL),
    .META_DATA_SIZE(META), .NUM_ROWS(NR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .buf_free(buf_free),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .weight_out(weight_out), .weight_transferring_out(weight_transferring_out),
    .wb_sel(wb_sel), .busy(busy), .done(done), .row_cnt(row_cnt)
  );

  typedef struct packed {
    logic         wb;
    logic         last;
    logic [W-1:0] data;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         cur_e;
  logic [W-1:0] last_w;
  int           n_chk  = 0;
  int           n_pass = 0;
  int           n_done = 0;

  // Reference model: a load is "waiting", "needing N more rows", or "finishing".
  bit m_wait;
  int m_rows_left;
  bit m_finish;
  bit m_wb;
  int m_cnt;
  int m_ndone;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string name, logic [W-1:0] got, logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endfunction

  function automatic logic [W-1:0] rnd_row();
    logic [W-1:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  // One clock: check current status against the model, advance model with applied inputs.
  task automatic step();
    chk("in_ready", in_ready, m_rows_left > 0);
    chk("busy", busy, m_wait || m_rows_left > 0 || m_finish);
    chk("wb_sel", wb_sel, m_wb);
    chk("row_cnt", row_cnt, m_cnt);
    if (m_finish) begin
      m_finish = 1'b0;
      m_wb     = ~m_wb;
    end else if (m_rows_left > 0) begin
      if (abort) begin
        m_rows_left = 0;
      end else if (in_valid) begin
        exp_q.push_back('{wb: m_wb, last: (m_rows_left == 1), data: in_data});
        m_rows_left--;
        m_cnt = (m_cnt + 1) % NR;
        if (m_rows_left == 0) begin
          m_finish = 1'b1;
          m_ndone++;
        end
      end
    end else if (m_wait) begin
      if (abort) m_wait = 1'b0;
      else if (buf_free[m_wb]) begin
        m_wait      = 1'b0;
        m_rows_left = NR;
      end
    end else if (start) begin
      m_wait = 1'b1;
      m_cnt  = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_wait = 1'b0; m_rows_left = 0; m_finish = 1'b0; m_wb = 1'b0; m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_weight_out"}, weight_out, '0);
    chk({tag, "_transferring"}, weight_transferring_out, '0);
    chk({tag, "_wb_sel"}, wb_sel, '0);
    chk({tag, "_row_cnt"}, row_cnt, '0);
    chk({tag, "_done"}, done, '0);
    chk({tag, "_in_ready"}, in_ready, '0);
    chk({tag, "_busy"}, busy, '0);
  endtask

  task automatic full_load();
    buf_free = 2'b11;
    start = 1'b1; step(); start = 1'b0;
    step();
    in_valid = 1'b1;
    repeat (NR) begin
      in_data = rnd_row();
      step();
    end
    in_valid = 1'b0;
    step(); step();
  endtask

  // Monitor: every transferring cycle must match the oldest predicted row.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_w = '0;
    end else if (weight_transferring_out) begin
      if (done) n_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1'b1, 1'b0);
      end else begin
        cur_e = exp_q.pop_front();
        chk("weight_out", weight_out, cur_e.data);
        chk("beat_wb_sel", wb_sel, cur_e.wb);
        chk("done_on_last", done, cur_e.last);
        last_w = cur_e.data;
      end
    end else begin
      chk("done_idle", done, 1'b0);
      chk("weight_hold", weight_out, last_w);
    end
  end

  initial begin
    logic [5:0] bub;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; buf_free = 2'b00;
    in_valid = 1'b0; in_data = '0;
    m_ndone = 0;
    model_reset();
    #3;
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic load with rows 0xA..0xD
    buf_free = 2'b11;
    start = 1'b1; step(); start = 1'b0;
    step();
    in_valid = 1'b1;
    for (int i = 0; i < NR; i++) begin
      in_data = W'(32'hA + i);
      step();
    end
    in_valid = 1'b0;
    step(); step();

    // Bubbles 1,0,1,1,0,1
    bub = 6'b101101;
    start = 1'b1; step(); start = 1'b0;
    step();
    for (int i = 5; i >= 0; i--) begin
      in_valid = bub[i];
      in_data  = rnd_row();
      step();
    end
    in_valid = 1'b0;
    step(); step();

    // Buffer wait: only the other buffer is free for 10 cycles
    buf_free = m_wb ? 2'b01 : 2'b10;
    in_valid = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    repeat (10) begin
      in_data = rnd_row();
      step();
    end
    buf_free = 2'b11;
    repeat (NR + 1) begin
      in_data = rnd_row();
      step();
    end
    in_valid = 1'b0;
    step(); step();

    // Abort after 2 beats, concurrent with a valid row
    start = 1'b1; step(); start = 1'b0;
    step();
    in_valid = 1'b1;
    repeat (2) begin in_data = rnd_row(); step(); end
    abort = 1'b1; in_data = rnd_row(); step();
    abort = 1'b0; in_valid = 1'b0;
    step(); step();
    full_load();

    // Back-to-back with a stray start during streaming
    start = 1'b1; step(); start = 1'b0;
    step();
    in_valid = 1'b1;
    for (int i = 0; i < NR; i++) begin
      in_data = rnd_row();
      start = (i == 1);
      step();
    end
    start = 1'b0; in_valid = 1'b0;
    step();
    full_load();

    // Asynchronous reset after one beat
    start = 1'b1; step(); start = 1'b0;
    step();
    in_valid = 1'b1; in_data = rnd_row(); step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    full_load();

    // Randomized traffic
    repeat (1500) begin
      start    = ($urandom_range(3) == 0);
      abort    = ($urandom_range(24) == 0);
      buf_free = 2'($urandom_range(3));
      in_valid = ($urandom_range(3) != 0);
      in_data  = rnd_row();
      step();
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b0; buf_free = 2'b00;
    repeat (8) step();

    chk("queue_drained", exp_q.size(), 0);
    chk("done_count", n_done, m_ndone);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
